bomb_stage_renderer: RTL and testbench

- Parametrised, pipelined successor to the fixed stage-picture renderer.
- Converts a pixel coordinate stream into RGB332 colour for one bomb stage: black border, green display panel with live countdown bar, and NUM_WIRES coloured wires that can each be shown cut.
- Adds state-driven animation: the outside region flashes on FAILURE, and the countdown bar turns red once the remaining time is low.
- Sits between the VGA/scaler coordinate generator and the pixel output mux.

---
 rtl/bomb_stage_renderer.sv | 192 +++++++++++++++++++
 tb/tb_bomb_stage_renderer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_stage_renderer.sv
// rtl/bomb_stage_renderer.sv - two-stage pipelined bomb stage picture renderer (RGB332)
module bomb_stage_renderer #(
   parameter int H_RES     = 80,
   parameter int V_RES     = 60,
   parameter int COORD_W   = 7,
   parameter int NUM_WIRES = 4,
   parameter int TIMER_W   = 8,
   parameter int FLASH_DIV = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pix_valid_in,
   input  logic [COORD_W-1:0]   x,
   input  logic [COORD_W-1:0]   y,
   input  logic                 frame_start,
   input  logic [1:0]           state,
   input  logic [NUM_WIRES-1:0] wire_cut,
   input  logic [TIMER_W-1:0]   time_left,
   input  logic [TIMER_W-1:0]   time_max,
   output logic                 pix_valid_out,
   output logic [7:0]           color
);

   typedef enum logic [1:0] {
      ST_WAITING   = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_SUCCESS   = 2'd2,
      ST_FAILURE   = 2'd3
   } game_state_t;

   typedef enum logic [2:0] {
      R_OUTSIDE    = 3'd0,
      R_BORDER     = 3'd1,
      R_BAR        = 3'd2,
      R_PANEL      = 3'd3,
      R_WIRE       = 3'd4,
      R_BACKGROUND = 3'd5
   } region_t;

   localparam int PITCH = (H_RES - 24) / NUM_WIRES;
   localparam int PW    = COORD_W + TIMER_W;
   localparam int FC_W  = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
   localparam logic [PW-1:0] PANEL_W_V = PW'(H_RES - 22);

   function automatic logic in_box(input logic [31:0] px, input logic [31:0] py,
                                   input logic [31:0] x0, input logic [31:0] x1,
                                   input logic [31:0] y0, input logic [31:0] y1);
      return (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1);
   endfunction

   game_state_t st_in;
   assign st_in = game_state_t'(state);

   // ---------------- flash sequencer ----------------
   logic [FC_W-1:0] frame_cnt;
   logic            flash_phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt   <= '0;
         flash_phase <= 1'b0;
      end else if (st_in != ST_FAILURE) begin
         frame_cnt   <= '0;
         flash_phase <= 1'b0;
      end else if (frame_start) begin
         if (frame_cnt == FC_W'(FLASH_DIV - 1)) begin
            frame_cnt   <= '0;
            flash_phase <= ~flash_phase;
         end else begin
            frame_cnt <= frame_cnt + FC_W'(1);
         end
      end
   end

   // ---------------- stage 0: region classification ----------------
   logic [31:0]        xi, yi;
   region_t            region;
   logic [1:0]         wire_sel;
   logic               wire_hit;
   logic [COORD_W-1:0] bar_off;
   logic [PW-1:0]      bar_lhs, bar_rhs;
   logic               bar_lit, warn;

   assign xi = {{(32-COORD_W){1'b0}}, x};
   assign yi = {{(32-COORD_W){1'b0}}, y};

   always_comb begin
      region   = R_OUTSIDE;
      wire_sel = 2'd0;
      wire_hit = 1'b0;
      if (xi >= H_RES || yi >= V_RES) begin
         region = R_OUTSIDE;
      end else if (in_box(xi, yi, 4, H_RES-5, 4, V_RES-5) &&
                   !in_box(xi, yi, 8, H_RES-9, 8, V_RES-9)) begin
         region = R_BORDER;
      end else if (in_box(xi, yi, 11, H_RES-12, 11, 16)) begin
         region = R_BAR;
      end else if (in_box(xi, yi, 9, H_RES-10, 9, 18)) begin
         region = R_PANEL;
      end else begin
         // A cut wire leaves a gap that shows the background behind it.
         for (int i = 0; i < NUM_WIRES; i++) begin
            if (!wire_hit && in_box(xi, yi, 12 + i*PITCH, 14 + i*PITCH, 22, 49) &&
                !(wire_cut[i] && yi >= 34 && yi <= 37)) begin
               wire_hit = 1'b1;
               wire_sel = 2'(i);
            end
         end
         if (wire_hit)
            region = R_WIRE;
         else if (in_box(xi, yi, 8, H_RES-9, 8, V_RES-9))
            region = R_BACKGROUND;
         else
            region = R_OUTSIDE;
      end
   end

   // Bar fill compares full-width cross products, so no division is needed.
   assign bar_off = x - COORD_W'(11);
   assign bar_lhs = {{TIMER_W{1'b0}}, bar_off} * {{COORD_W{1'b0}}, time_max};
   assign bar_rhs = {{COORD_W{1'b0}}, time_left} * PANEL_W_V;
   assign bar_lit = (time_max != '0) && (bar_lhs < bar_rhs);
   assign warn    = (st_in == ST_COUNTDOWN) &&
                    (({2'b00, time_left} << 2) < {2'b00, time_max});

   // ---------------- stage 1 registers ----------------
   logic        v1;
   region_t     region1;
   logic [1:0]  wire_sel1;
   logic        lit1, warn1;
   game_state_t state1;
   logic        phase1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         region1   <= R_OUTSIDE;
         wire_sel1 <= 2'd0;
         lit1      <= 1'b0;
         warn1     <= 1'b0;
         state1    <= ST_WAITING;
         phase1    <= 1'b0;
      end else begin
         v1        <= pix_valid_in;
         region1   <= region;
         wire_sel1 <= wire_sel;
         lit1      <= bar_lit;
         warn1     <= warn;
         state1    <= st_in;
         phase1    <= flash_phase;
      end
   end

   // ---------------- stage 2: colour lookup ----------------
   logic [7:0] color_next;

   always_comb begin
      color_next = 8'h00;
      case (region1)
         R_BORDER:     color_next = 8'h00;
         R_BAR:        color_next = lit1 ? (warn1 ? 8'hE0 : 8'hFC) : 8'h0C;
         R_PANEL:      color_next = 8'h0C;
         R_WIRE: begin
            case (wire_sel1)
               2'd0:    color_next = 8'hE0;
               2'd1:    color_next = 8'h90;
               2'd2:    color_next = 8'h2B;
               default: color_next = 8'h35;
            endcase
         end
         R_BACKGROUND: color_next = 8'hB6;
         default: begin
            case (state1)
               ST_SUCCESS: color_next = 8'h15;
               ST_FAILURE: color_next = phase1 ? 8'h00 : 8'hA4;
               default:    color_next = 8'h49;
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_valid_out <= 1'b0;
         color         <= 8'h00;
      end else begin
         pix_valid_out <= v1;
         color         <= v1 ? color_next : 8'h00;
      end
   end

endmodule

// File: tb/tb_bomb_stage_renderer.sv
// tb/tb_bomb_stage_renderer.sv - scoreboard bench for bomb_stage_renderer
module tb_bomb_stage_renderer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pix_valid_in;
   logic [6:0] x, y;
   logic       frame_start;
   logic [1:0] state;
   logic [3:0] wire_cut;
   logic [7:0] time_left, time_max;
   logic       pix_valid_out;
   logic [7:0] color;

   bomb_stage_renderer #(
      .H_RES(80), .V_RES(60), .COORD_W(7), .NUM_WIRES(4), .TIMER_W(8), .FLASH_DIV(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_valid_in(pix_valid_in), .x(x), .y(y),
      .frame_start(frame_start), .state(state), .wire_cut(wire_cut),
      .time_left(time_left), .time_max(time_max),
      .pix_valid_out(pix_valid_out), .color(color)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] col;
      int         due;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   logic mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [7:0] ref_color(input int px, input int py, input int st,
                                            input logic [3:0] cut, input int tl,
                                            input int tm, input int ph);
      if (px >= 80 || py >= 60) begin
      end else if (px >= 4 && px <= 75 && py >= 4 && py <= 55 &&
                   !(px >= 8 && px <= 71 && py >= 8 && py <= 51)) begin
         return 8'h00;
      end else if (py >= 11 && py <= 16 && px >= 11 && px <= 68) begin
         if (tm != 0 && (px - 11) * tm < tl * 58)
            return (st == 1 && 4 * tl < tm) ? 8'hE0 : 8'hFC;
         return 8'h0C;
      end else if (px >= 9 && px <= 70 && py >= 9 && py <= 18) begin
         return 8'h0C;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (px >= 12 + 14*i && px <= 14 + 14*i && py >= 22 && py <= 49 &&
                !(cut[i] && py >= 34 && py <= 37)) begin
               case (i)
                  0: return 8'hE0;
                  1: return 8'h90;
                  2: return 8'h2B;
                  default: return 8'h35;
               endcase
            end
         end
         if (px >= 8 && px <= 71 && py >= 8 && py <= 51) return 8'hB6;
      end
      if (st == 2) return 8'h15;
      if (st == 3) return (ph != 0) ? 8'h00 : 8'hA4;
      return 8'h49;
   endfunction

   task automatic send(input int px, input int py, input logic fs, input logic [7:0] e);
      exp_t item;
      @(posedge clk); #1;
      x = 7'(px);
      y = 7'(py);
      frame_start = fs;
      pix_valid_in = 1'b1;
      item.col = e;
      item.due = cyc + 2;
      q.push_back(item);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      pix_valid_in = 1'b0;
      frame_start  = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) idle();
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a pixel.
   always @(negedge clk) begin
      if (mon_en) begin
         if (pix_valid_out) begin
            chk("valid_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               exp_t e;
               e = q.pop_front();
               chk("latency", cyc, e.due);
               chk("color", {24'h0, color}, {24'h0, e.col});
            end
         end else begin
            chk("idle_color", {24'h0, color}, 32'h0);
            if (q.size() != 0 && q[0].due <= cyc) begin
               chk("output_missing", {31'h0, pix_valid_out}, 32'd1);
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
      $fatal(1, "timeout");
   end

   logic [7:0] fl_exp [5] = '{8'hA4, 8'hA4, 8'h00, 8'h00, 8'hA4};

   initial begin
      rst_n = 1'b0; pix_valid_in = 1'b0; x = '0; y = '0; frame_start = 1'b0;
      state = 2'd0; wire_cut = '0; time_left = '0; time_max = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", {31'h0, pix_valid_out}, 32'd0);
      chk("reset_color", {24'h0, color}, 32'h0);
      mon_en = 1'b1;
      rst_n = 1'b1;
      gap(2);

      // First pixel after reset, WAITING outside colour
      send(0, 0, 1'b0, 8'h49);
      gap(4);

      // Countdown bar sweeps
      state = 2'd1; time_max = 8'd100; time_left = 8'd50;
      for (int i = 11; i <= 68; i++) send(i, 12, 1'b0, (i <= 39) ? 8'hFC : 8'h0C);
      idle();
      time_left = 8'd20;
      for (int i = 11; i <= 68; i++) send(i, 12, 1'b0, (i <= 22) ? 8'hE0 : 8'h0C);
      idle();
      time_max = 8'd0;
      for (int i = 11; i <= 68; i++) send(i, 12, 1'b0, 8'h0C);
      idle();

      // Wires and cut gap
      state = 2'd0; wire_cut = 4'b0010; time_max = 8'd100; time_left = 8'd50;
      send(26, 30, 1'b0, 8'h90);
      send(26, 35, 1'b0, 8'hB6);
      send(12, 35, 1'b0, 8'hE0);
      send(40, 30, 1'b0, 8'h2B);
      send(56, 49, 1'b0, 8'h35);
      send(57, 30, 1'b0, 8'hB6);

      // Region boundaries
      send(4, 4, 1'b0, 8'h00);
      send(75, 55, 1'b0, 8'h00);
      send(3, 4, 1'b0, 8'h49);
      send(80, 10, 1'b0, 8'h49);
      send(8, 8, 1'b0, 8'hB6);
      send(76, 55, 1'b0, 8'h49);
      send(9, 9, 1'b0, 8'h0C);
      idle();

      // Failure flash, pixel coincident with frame_start each frame
      state = 2'd3;
      for (int f = 0; f < 5; f++) begin
         send(1, 1, 1'b1, fl_exp[f]);
         gap(3);
      end
      state = 2'd2;
      send(1, 1, 1'b0, 8'h15);
      gap(2);
      state = 2'd3;
      send(1, 1, 1'b1, 8'hA4);
      send(1, 1, 1'b1, 8'hA4);
      send(1, 1, 1'b1, 8'h00);
      gap(3);

      // Full back-to-back frame against the reference model
      state = 2'd1; time_max = 8'd100; time_left = 8'd20; wire_cut = 4'b0101;
      for (int j = 0; j < 60; j++)
         for (int i = 0; i < 80; i++)
            send(i, j, 1'b0, ref_color(i, j, 1, 4'b0101, 20, 100, 0));
      idle();
      gap(3);

      // Reset asserted mid-stream
      state = 2'd2; wire_cut = 4'b0000; time_left = 8'd50;
      for (int i = 0; i < 50; i++) send(i, 10, 1'b0, ref_color(i, 10, 2, 4'b0000, 50, 100, 0));
      @(posedge clk); #1;
      pix_valid_in = 1'b0;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("midreset_valid", {31'h0, pix_valid_out}, 32'd0);
      chk("midreset_color", {24'h0, color}, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      gap(3);
      send(10, 10, 1'b0, ref_color(10, 10, 2, 4'b0000, 50, 100, 0));
      send(40, 30, 1'b0, ref_color(40, 30, 2, 4'b0000, 50, 100, 0));
      send(0, 30, 1'b0, 8'h15);
      idle();

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
